// File: rtl/delay_fifo_pkg.sv
// -----------------------------------------------------------------------------
// delay_fifo_pkg
// Shared definitions for the per-entry-delay FIFO:
//   - default parameter constants
//   - pointer-width and count-width derivation helpers
//   - entry-record layout (data, release stamp, matured flag)
// Memory word layout: {stamp, data}, with data in the low DATA_WIDTH bits.
// The matured flag is not stored in the memory word. It is kept in a
// flop vector beside it, because every entry must be updated each cycle.
// -----------------------------------------------------------------------------
package delay_fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 4;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_DELAY_WIDTH = 8;

    // Default-width view of one entry record, for reference and debug.
    typedef struct packed {
        logic [DEF_DELAY_WIDTH-1:0] stamp;
        logic [DEF_DATA_WIDTH-1:0]  data;
        logic                       matured;
    } entry_t;

    // Read/write pointer width; DEPTH is a power of two, >= 2.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of one stored memory word ({stamp, data}).
    function automatic int entry_width(input int data_width, input int delay_width);
        return data_width + delay_width;
    endfunction

endpackage : delay_fifo_pkg

// File: rtl/delay_fifo_mem.sv
// -----------------------------------------------------------------------------
// delay_fifo_mem
// DEPTH x (DATA_WIDTH + DELAY_WIDTH) register array holding {stamp, data}.
// The array has one synchronous write port and one asynchronous read port for
// the head payload.
// It also has a parallel tap of every stored stamp. The parent compares each
// stamp against the free-running timer every cycle. Because of that, the stamp
// field is exposed as a flat vector.
// The contents are deliberately never reset.
//
// Ports:
//   clk         in   clock
//   i_wr_en     in   write strobe
//   i_wr_addr   in   write address
//   i_wr_data   in   payload to store
//   i_wr_stamp  in   release stamp to store
//   i_rd_addr   in   asynchronous read address (FIFO head)
//   o_rd_data   out  payload at i_rd_addr
//   o_stamps    out  all stamps, slot i at [i*DELAY_WIDTH +: DELAY_WIDTH]
// -----------------------------------------------------------------------------
module delay_fifo_mem
    import delay_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_WIDTH  = ptr_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         i_wr_en,
    input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [DELAY_WIDTH-1:0]       i_wr_stamp,
    input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
    output logic [DEPTH*DELAY_WIDTH-1:0] o_stamps
);

    localparam int ENTRY_W = entry_width(DATA_WIDTH, DELAY_WIDTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= {i_wr_stamp, i_wr_data};
        end
    end

    assign o_rd_data = r_mem[i_rd_addr][DATA_WIDTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stamp_tap
            assign o_stamps[gi*DELAY_WIDTH +: DELAY_WIDTH] = r_mem[gi][ENTRY_W-1 -: DELAY_WIDTH];
        end
    endgenerate

endmodule : delay_fifo_mem

// File: rtl/delay_fifo.sv
// -----------------------------------------------------------------------------
// delay_fifo
// Synchronous FIFO in which every entry carries its own release delay.
// An entry becomes readable only once its delay has elapsed. Strict FIFO order
// is kept, so an unmatured head blocks younger entries behind it.
//
// Optional feature macro: DELAY_FIFO_ERR_FLAGS_EN
//   - defined:   ovf and udf are sticky error flags, cleared only by rst.
//   - undefined: ovf and udf are tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   wr_valid     in   producer offers an entry
//   wr_ready     out  FIFO can accept (= !full)
//   wr_data      in   payload
//   wr_delay     in   release delay in cycles for this entry
//   rd_valid     out  head present and matured
//   rd_ready     in   consumer accepts head
//   rd_data      out  head payload, 0 when rd_valid=0
//   count        out  stored entries, matured or not
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_LEVEL
//   ovf          out  sticky: write offered while full
//   udf          out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module delay_fifo
    import delay_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DELAY_WIDTH-1:0]  wr_delay,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    ovf,
    output logic                    udf
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;
    logic [DELAY_WIDTH-1:0]       r_timer;

    logic [DEPTH-1:0]             w_matured;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_wr_fire;
    logic                         w_rd_fire;
    logic [DELAY_WIDTH-1:0]       w_wr_stamp;
    logic [DATA_WIDTH-1:0]        w_head_data;
    logic [DEPTH*DELAY_WIDTH-1:0] w_stamps;

    // Status decode, taken from registered state only.
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign almost_full = (r_count >= CNT_W'(AFULL_LEVEL));

    // Handshake outputs are driven only from registered state.
    assign wr_ready = !w_full;
    assign rd_valid = !w_empty && w_matured[r_rd_ptr];
    assign rd_data  = rd_valid ? w_head_data : '0;

    assign w_wr_fire = wr_valid && !w_full;
    assign w_rd_fire = rd_valid && rd_ready;

    // The release stamp wraps modulo 2^DELAY_WIDTH, together with the timer.
    assign w_wr_stamp = r_timer + wr_delay;

    // Free-running release timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + DELAY_WIDTH'(1);
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    delay_fifo_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DELAY_WIDTH (DELAY_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (PTR_W)
    ) u_mem (
        .clk        (clk),
        .i_wr_en    (w_wr_fire),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (wr_data),
        .i_wr_stamp (w_wr_stamp),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (w_head_data),
        .o_stamps   (w_stamps)
    );

    // Per-slot matured flag.
    // A write into the slot reloads the flag: it is set at once for a zero
    // delay, otherwise cleared. Reading the slot clears the flag. Otherwise
    // the flag latches when the timer reaches the slot's stamp, and it then
    // holds through any number of timer wraps.
    // Free slots may latch on stale stamps. That is harmless: rd_valid is
    // gated by !empty, and the next write into the slot reloads the flag.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mature
            logic                   r_mat;
            logic [DELAY_WIDTH-1:0] w_stamp;

            assign w_stamp = w_stamps[gi*DELAY_WIDTH +: DELAY_WIDTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mat <= 1'b0;
                end else if (w_wr_fire && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mat <= (wr_delay == '0);
                end else if (w_rd_fire && (r_rd_ptr == PTR_W'(gi))) begin
                    r_mat <= 1'b0;
                end else if (w_stamp == r_timer) begin
                    r_mat <= 1'b1;
                end
            end

            assign w_matured[gi] = r_mat;
        end
    endgenerate

`ifdef DELAY_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_ready && !rd_valid && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule : delay_fifo

// File: tb/tb_delay_fifo.sv
// -----------------------------------------------------------------------------
// tb_delay_fifo
// Directed self-checking bench for delay_fifo with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_delay_fifo;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic [7:0] wr_delay;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       ovf;
    logic       udf;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DELAY_FIFO_ERR_FLAGS_EN
    localparam logic FLAG_EXP = 1'b1;
`else
    localparam logic FLAG_EXP = 1'b0;
`endif

    delay_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_delay    (wr_delay),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [7:0] dl);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_delay = dl;
        step();
        wr_valid = 1'b0;
        $display("write data=%0h delay=%0d count=%0d", d, dl, count);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_delay = '0;
        rd_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_wr_ready",    wr_ready,    1);
        chk("rst_rd_valid",    rd_valid,    0);
        chk("rst_rd_data",     rd_data,     0);
        chk("rst_count",       count,       0);
        chk("rst_full",        full,        0);
        chk("rst_empty",       empty,       1);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_ovf",         ovf,         0);
        chk("rst_udf",         udf,         0);

        // Zero delay: visible the cycle after the write.
        // rd_ready=1 on an empty FIFO during the write edge flags underflow.
        rd_ready = 1'b1;
        push(4'hA, 8'd0);
        chk("d0_rd_valid", rd_valid, 1);
        chk("d0_rd_data",  rd_data,  4'hA);
        chk("d0_count",    count,    1);
        chk("d0_udf",      udf,      FLAG_EXP);
        step();
        rd_ready = 1'b0;
        $display("read  zero-delay entry, count=%0d", count);
        chk("d0_empty",      empty,    1);
        chk("d0_rd_valid_e", rd_valid, 0);
        chk("d0_rd_data_e",  rd_data,  0);

        // Delay of 5: readable only after edge k+5.
        push(4'h3, 8'd5);
        chk("d5_k0", rd_valid, 0);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk($sformatf("d5_k%0d", j), rd_valid, 0);
        end
        step();
        chk("d5_k5_valid", rd_valid, 1);
        chk("d5_k5_data",  rd_data,  4'h3);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        $display("read  delay-5 entry, count=%0d", count);
        chk("d5_empty", empty, 1);

        // Head-of-line blocking: A with D=10, then B with D=0.
        push(4'hA, 8'd10);
        chk("hol_k0", rd_valid, 0);
        push(4'hB, 8'd0);
        chk("hol_count", count,    2);
        chk("hol_k1",    rd_valid, 0);
        for (int j = 2; j <= 9; j++) begin
            step();
            chk($sformatf("hol_k%0d", j), rd_valid, 0);
        end
        step();
        chk("hol_k10_valid", rd_valid, 1);
        chk("hol_k10_data",  rd_data,  4'hA);
        // Read A while writing C: count must stay unchanged.
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 4'hC;
        wr_delay = 8'd0;
        step();
        wr_valid = 1'b0;
        $display("read  A + write C, count=%0d", count);
        chk("hol_rw_count", count,    2);
        chk("hol_b_valid",  rd_valid, 1);
        chk("hol_b_data",   rd_data,  4'hB);
        step();
        $display("read  B, count=%0d", count);
        chk("hol_c_count", count,   1);
        chk("hol_c_data",  rd_data, 4'hC);
        step();
        rd_ready = 1'b0;
        $display("read  C, count=%0d", count);
        chk("hol_empty", empty, 1);
        chk("hol_count0", count, 0);

        // Fill to full with D=0 and no reads.
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 8'd0);
            chk($sformatf("fill%0d_count", i), count,       i + 1);
            chk($sformatf("fill%0d_afull", i), almost_full, (i + 1) >= 14);
            chk($sformatf("fill%0d_full",  i), full,        (i + 1) == 16);
            chk($sformatf("fill%0d_wrdy",  i), wr_ready,    (i + 1) != 16);
        end
        push(4'hF, 8'd0);
        chk("ovf_count", count, 16);
        chk("ovf_full",  full,  1);
        chk("ovf_flag",  ovf,   FLAG_EXP);
        // Drain: order must be 0..15, and the dropped 0xF must never appear.
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), rd_valid, 1);
            chk($sformatf("drain%0d_data",  i), rd_data,  i);
            step();
            $display("read  drain %0d, count=%0d", i, count);
        end
        rd_ready = 1'b0;
        chk("drain_empty", empty, 1);

        // Reset in the middle of traffic with 5 entries stored.
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 1), 8'd3);
        end
        chk("mid_count5", count, 5);
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 4'h9;
        rd_ready = 1'b1;
        step();
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        $display("reset mid-traffic, count=%0d", count);
        chk("mid_count",    count,    0);
        chk("mid_empty",    empty,    1);
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_rd_data",  rd_data,  0);
        chk("mid_ovf",      ovf,      0);
        chk("mid_udf",      udf,      0);
        chk("mid_wr_ready", wr_ready, 1);
        push(4'h5, 8'd0);
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_data",  rd_data,  4'h5);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("post_rst_empty", empty, 1);

        // Timer wrap: D=255 written after the timer has run for a while.
        repeat (300) step();
        push(4'h7, 8'd255);
        chk("wrap_j0", rd_valid, 0);
        for (int j = 1; j <= 600; j++) begin
            step();
            chk($sformatf("wrap_j%0d", j), rd_valid, j >= 255);
        end
        chk("wrap_data", rd_data, 4'h7);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        $display("read  wrap entry, count=%0d", count);
        chk("wrap_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_delay_fifo
